// File: rtl/mips_data_mem_responder_if.sv
// Data-memory bus between the MIPS datapath (master) and the data-memory
// responder (slave). Carries the load/store strobes, address, store data,
// and the responder's read data, stall and write-buffer status.
interface mips_data_mem_responder_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int WB_DEPTH   = 4
);
    localparam int CNT_W = $clog2(WB_DEPTH) + 1;

    logic                  MEM_WR_EN;
    logic                  MEM_RD_EN;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wr_data;
    logic [DATA_WIDTH-1:0] mem_rd_data;
    logic                  STALL;
    logic [CNT_W-1:0]      wb_count;
    logic                  wb_empty;

    modport master (
        output MEM_WR_EN, MEM_RD_EN, mem_addr, mem_wr_data,
        input  mem_rd_data, STALL, wb_count, wb_empty
    );

    modport slave (
        input  MEM_WR_EN, MEM_RD_EN, mem_addr, mem_wr_data,
        output mem_rd_data, STALL, wb_count, wb_empty
    );
endinterface

// File: rtl/mips_data_mem_responder.sv
// Data-memory responder for the MIPS datapath. Stores are posted into a
// circular write buffer and drained into a single-port word RAM on idle
// cycles, or forcibly while STALL is high. Loads are combinational.
// Optional feature macro: DMEM_RAW_FWD_EN -- when defined, loads are
// forwarded from the newest matching buffer entry; when undefined, a load
// that hits the buffer stalls until every matching entry has drained.
module mips_data_mem_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_DEPTH  = 256,
    parameter int WB_DEPTH   = 4
) (
    input logic                     CLK,
    input logic                     RST_N,
    mips_data_mem_responder_if.slave bus
);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int PTR_W = $clog2(WB_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef logic [IDX_W-1:0]      idx_t;
    typedef logic [DATA_WIDTH-1:0] word_t;

    word_t             ram     [MEM_DEPTH];
    idx_t              wb_idx  [WB_DEPTH];
    word_t             wb_data [WB_DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;

    idx_t  idx;
    logic  full;
    logic  hit;
    word_t hit_data;
    word_t rd_word;
    logic  read_stall;
    logic  stall;
    logic  push;
    logic  drain;

    // Word index; byte-offset bits and bits above the RAM range are ignored.
    assign idx  = bus.mem_addr[IDX_W+1:2];
    assign full = (count == CNT_W'(WB_DEPTH));

    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.mem_addr[ADDR_WIDTH-1:IDX_W+2], bus.mem_addr[1:0]};

    // Search valid entries oldest to newest so the newest match wins.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        hit      = 1'b0;
        hit_data = '0;
        for (int k = 0; k < WB_DEPTH; k++) begin
            if (CNT_W'(k) < count && wb_idx[head + PTR_W'(k)] == idx) begin
                hit      = 1'b1;
                hit_data = wb_data[head + PTR_W'(k)];
            end
        end
    end

`ifdef DMEM_RAW_FWD_EN
    assign read_stall = 1'b0;
    assign rd_word    = hit ? hit_data : ram[idx];
`else
    // Without forwarding a RAW hazard stalls until the matching entries drain.
    assign read_stall = bus.MEM_RD_EN & hit;
    assign rd_word    = ram[idx];

    logic unused_hit_data;
    assign unused_hit_data = ^hit_data;
`endif

    assign stall = (bus.MEM_WR_EN & full) | read_stall;
    assign push  = bus.MEM_WR_EN & ~stall;
    assign drain = (count != '0) & ((~bus.MEM_RD_EN & ~bus.MEM_WR_EN) | stall);

    assign bus.STALL       = stall;
    assign bus.wb_count    = count;
    assign bus.wb_empty    = (count == '0);
    assign bus.mem_rd_data = bus.MEM_RD_EN ? rd_word : '0;

    // Buffer bookkeeping; push and drain never coincide, so count moves by one.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            if (push)  tail <= tail + PTR_W'(1);
            if (drain) head <= head + PTR_W'(1);
            case ({push, drain})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Buffer payload capture and RAM write-back on the drain edge.
    always_ff @(posedge CLK) begin
        // NOTE: storage arrays carry no reset; validity comes from the reset pointers and count.
        if (push) begin
            wb_idx[tail]  <= idx;
            wb_data[tail] <= bus.mem_wr_data;
        end
        if (drain) begin
            ram[wb_idx[head]] <= wb_data[head];
        end
    end
endmodule

// File: tb/tb_mips_data_mem_responder.sv
// Self-checking bench for mips_data_mem_responder: a queue-based model of
// the write buffer plus an array RAM model is compared against the DUT on
// every falling edge, alongside directed literal expectations.
module tb_mips_data_mem_responder;
    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 32;
    localparam int MEM_DEPTH  = 256;
    localparam int WB_DEPTH   = 4;

`ifdef DMEM_RAW_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    mips_data_mem_responder_if #(
        .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .WB_DEPTH(WB_DEPTH)
    ) bus ();

    mips_data_mem_responder #(
        .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
        .MEM_DEPTH(MEM_DEPTH), .WB_DEPTH(WB_DEPTH)
    ) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int unsigned idx;
        logic [31:0] data;
    } entry_t;

    entry_t      wbq [$];
    logic [31:0] ram_m     [MEM_DEPTH];
    bit          ram_known [MEM_DEPTH];

    function automatic int unsigned word_of(logic [31:0] a);
        return (a >> 2) % MEM_DEPTH;
    endfunction

    function automatic bit any_match(int unsigned w);
        foreach (wbq[i]) if (wbq[i].idx == w) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_stall();
        return (bus.MEM_WR_EN && wbq.size() == WB_DEPTH) ||
               (!FWD && bus.MEM_RD_EN && any_match(word_of(bus.mem_addr)));
    endfunction

    // Returns 1 when the expected read value is known.
    function automatic bit m_read(output logic [31:0] v);
        int unsigned w;
        v = '0;
        if (!bus.MEM_RD_EN) return 1'b1;
        w = word_of(bus.mem_addr);
        if (FWD) begin
            for (int i = wbq.size() - 1; i >= 0; i--) begin
                if (wbq[i].idx == w) begin
                    v = wbq[i].data;
                    return 1'b1;
                end
            end
        end
        v = ram_m[w];
        return ram_known[w];
    endfunction

    always @(posedge CLK or negedge RST_N) begin : model_update
        bit     st, pu, dr;
        entry_t e;
        if (!RST_N) begin
            wbq.delete();
        end else begin
            st = m_stall();
            pu = bus.MEM_WR_EN && !st;
            dr = (wbq.size() != 0) && ((!bus.MEM_RD_EN && !bus.MEM_WR_EN) || st);
            if (dr) begin
                e = wbq.pop_front();
                ram_m[e.idx]     <= e.data;
                ram_known[e.idx] <= 1'b1;
            end
            if (pu) wbq.push_back('{word_of(bus.mem_addr), bus.mem_wr_data});
        end
    end

    always @(negedge CLK) begin : compare
        logic [31:0] exp_rd;
        bit          known, st;
        if (chk_en) begin
            st = m_stall();
            check("m_stall", {31'b0, bus.STALL}, {31'b0, st});
            check("m_wb_count", {29'b0, bus.wb_count}, wbq.size());
            check("m_wb_empty", {31'b0, bus.wb_empty}, {31'b0, wbq.size() == 0});
            known = m_read(exp_rd);
            if (known && !st) check("m_rd_data", bus.mem_rd_data, exp_rd);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(bit wr, bit rd, logic [31:0] a, logic [31:0] d);
        bus.MEM_WR_EN   = wr;
        bus.MEM_RD_EN   = rd;
        bus.mem_addr    = a;
        bus.mem_wr_data = d;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(int n);
        drive(1'b0, 1'b0, '0, '0);
        repeat (n) tick();
    endtask

    task automatic store(logic [31:0] a, logic [31:0] d);
        drive(1'b1, 1'b0, a, d);
        tick();
    endtask

    // Hold a load until STALL drops (bounded), then check value and count.
    task automatic load_settle(logic [31:0] a, int exp_stalls, logic [31:0] exp_d,
                               int exp_cnt, string name);
        int n = 0;
        drive(1'b0, 1'b1, a, '0);
        #1;
        while (bus.STALL && n < 16) begin
            tick();
            n++;
        end
        if (n == 16) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: STALL still high after %0d cycles", name, n);
        end
        check({name, "_stalls"}, n, exp_stalls);
        check({name, "_data"}, bus.mem_rd_data, exp_d);
        check({name, "_count"}, {29'b0, bus.wb_count}, exp_cnt);
        tick();
    endtask

    task automatic reset_pulse();
        #2 RST_N = 1'b0;
        #1;
        check("rst_count", {29'b0, bus.wb_count}, 0);
        check("rst_stall", {31'b0, bus.STALL}, 0);
        check("rst_empty", {31'b0, bus.wb_empty}, 1);
        drive(1'b0, 1'b0, '0, '0);
        @(posedge CLK);
        #1 RST_N = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        drive(1'b0, 1'b0, '0, '0);
        repeat (3) @(posedge CLK);
        #1 RST_N = 1'b1;
        #1;
        check("init_count", {29'b0, bus.wb_count}, 0);
        check("init_empty", {31'b0, bus.wb_empty}, 1);
        check("init_stall", {31'b0, bus.STALL}, 0);
        check("init_rd_idle", bus.mem_rd_data, 0);
        chk_en = 1'b1;
        tick();
        drive(1'b0, 1'b1, 32'h0, '0);
        tick();

        // Single store then load of the same word.
        store(32'h10, 32'hDEAD_BEEF);
        load_settle(32'h10, FWD ? 0 : 1, 32'hDEAD_BEEF, FWD ? 1 : 0, "raw_single");

        // Two stores to one word: the newer value must win.
        store(32'h20, 32'h1);
        store(32'h20, 32'h2);
        load_settle(32'h20, FWD ? 0 : 2, 32'h2, FWD ? 3 : 0, "raw_newest");
        idle(3);
        check("drain_empty", {31'b0, bus.wb_empty}, 1);
        load_settle(32'h20, 0, 32'h2, 0, "ram_after_drain");

        // Fill the buffer, then a fifth store stalls exactly one cycle.
        store(32'h0, 32'h11);
        store(32'h4, 32'h22);
        store(32'h8, 32'h33);
        store(32'hC, 32'h44);
        drive(1'b1, 1'b0, 32'h10, 32'h55);
        #1;
        check("full_stall", {31'b0, bus.STALL}, 1);
        check("full_count", {29'b0, bus.wb_count}, 4);
        tick();
        check("full_after_drain_stall", {31'b0, bus.STALL}, 0);
        check("full_after_drain_count", {29'b0, bus.wb_count}, 3);
        @(posedge CLK);
        #1;
        drive(1'b0, 1'b0, '0, '0);
        check("full_accepted_count", {29'b0, bus.wb_count}, 4);
        idle(4);
        check("full_drained_empty", {31'b0, bus.wb_empty}, 1);
        load_settle(32'h0, 0, 32'h11, 0, "ram_w0");
        load_settle(32'h4, 0, 32'h22, 0, "ram_w1");
        load_settle(32'h8, 0, 32'h33, 0, "ram_w2");
        load_settle(32'hC, 0, 32'h44, 0, "ram_w3");
        load_settle(32'h10, 0, 32'h55, 0, "ram_w4");

        // RAW on a single entry, with ignored low and high address bits.
        store(32'h40, 32'hA5A5_A5A5);
        load_settle(32'hFFFF_FC43, FWD ? 0 : 1, 32'hA5A5_A5A5, FWD ? 1 : 0, "raw_a5");
        idle(2);

        // Illegal read+write: treated as a store, no idle drain.
        store(32'h100, 32'h77);
        drive(1'b1, 1'b1, 32'h104, 32'h88);
        tick();
        drive(1'b0, 1'b0, '0, '0);
        check("rdwr_count", {29'b0, bus.wb_count}, 2);
        idle(3);

        // Reset discards buffered stores; RAM keeps older contents.
        store(32'h80, 32'h100);
        store(32'h84, 32'h200);
        store(32'h88, 32'h300);
        idle(4);
        store(32'h80, 32'hAAA1);
        store(32'h84, 32'hAAA2);
        store(32'h88, 32'hAAA3);
        drive(1'b0, 1'b0, '0, '0);
        check("pre_reset_count", {29'b0, bus.wb_count}, 3);
        reset_pulse();
        load_settle(32'h80, 0, 32'h100, 0, "post_reset_w0");
        load_settle(32'h84, 0, 32'h200, 0, "post_reset_w1");
        load_settle(32'h88, 0, 32'h300, 0, "post_reset_w2");

        // Reset during a full-buffer stall drops STALL immediately.
        store(32'hC0, 32'h1);
        store(32'hC4, 32'h2);
        store(32'hC8, 32'h3);
        store(32'hCC, 32'h4);
        drive(1'b1, 1'b0, 32'hD0, 32'h5);
        #1;
        check("stall_before_reset", {31'b0, bus.STALL}, 1);
        reset_pulse();
        idle(2);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
